// File: rtl/pipelined_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined adder.
package pipelined_adder_pkg;

    // Per-stage control register: beat valid flag and carry out of the segment.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    // Width of one carry-chain segment.
    function automatic int cw(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

    // Legal parameter set: 1 <= stages <= width and the segments tile the word exactly.
    function automatic bit params_ok(input int width, input int stages);
        if (stages < 1 || stages > width) begin
            return 1'b0;
        end
        return (width % stages) == 0;
    endfunction

endpackage

// File: rtl/pipelined_adder_full_adder_slice.sv
// Combinational ripple adder segment built from full-adder bit cells.
module full_adder_slice
    import pipelined_adder_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    // Ripple the carry through W full-adder cells: sum = a^b^c, carry = majority(a,b,c).
    always_comb begin
        logic carry;
        carry = ci;
        s     = '0;
        for (int i = 0; i < W; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
        end
        co = carry;
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder with carry-in, carry chain split over STAGES
// register stages, valid/ready handshake with full back-pressure.
// Optional signed-overflow output enabled by defining PIPE_ADDER_OVF_EN.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cw(WIDTH, STAGES);

    if (!params_ok(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    // The whole pipe moves together; it only stalls when a result is waiting unaccepted.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Stage k consumes the operand bits from segment k upward and has
        // produced sum bits for segments 0..k.
        localparam int SRC_W = WIDTH - k * CW;
        localparam int LO_W  = (k + 1) * CW;

        stage_ctl_t       src_ctl;
        stage_ctl_t       ctl_q;
        logic [SRC_W-1:0] src_a;
        logic [SRC_W-1:0] src_b;
        logic [CW-1:0]    seg_s;
        logic             seg_co;
        logic [LO_W-1:0]  sum_d;
        logic [LO_W-1:0]  sum_q;
`ifdef PIPE_ADDER_OVF_EN
        logic             src_amsb;
        logic             src_bmsb;
        logic             amsb_q;
        logic             bmsb_q;
`endif

        if (k == 0) begin : g_head
            assign src_ctl = '{valid: in_valid, carry: cin};
            assign src_a   = a;
            assign src_b   = b;
            assign sum_d   = seg_s;
`ifdef PIPE_ADDER_OVF_EN
            assign src_amsb = a[WIDTH-1];
            assign src_bmsb = b[WIDTH-1];
`endif
        end else begin : g_link
            assign src_ctl = g_stage[k-1].ctl_q;
            assign src_a   = g_stage[k-1].g_fwd.a_q;
            assign src_b   = g_stage[k-1].g_fwd.b_q;
            assign sum_d   = {seg_s, g_stage[k-1].sum_q};
`ifdef PIPE_ADDER_OVF_EN
            assign src_amsb = g_stage[k-1].amsb_q;
            assign src_bmsb = g_stage[k-1].bmsb_q;
`endif
        end

        full_adder_slice #(
            .W (CW)
        ) u_slice (
            .a  (src_a[CW-1:0]),
            .b  (src_b[CW-1:0]),
            .ci (src_ctl.carry),
            .s  (seg_s),
            .co (seg_co)
        );

        // Stage register: valid flag, segment carry and accumulated low sum bits.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ctl_q <= '0;
                sum_q <= '0;
            end else if (advance) begin
                ctl_q.valid <= src_ctl.valid;
                ctl_q.carry <= seg_co;
                sum_q       <= sum_d;
            end
        end

`ifdef PIPE_ADDER_OVF_EN
        // Operand sign bits ride alongside the beat so the last stage can judge overflow.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                amsb_q <= 1'b0;
                bmsb_q <= 1'b0;
            end else if (advance) begin
                amsb_q <= src_amsb;
                bmsb_q <= src_bmsb;
            end
        end
`endif

        if (k < STAGES - 1) begin : g_fwd
            logic [SRC_W-CW-1:0] a_q;
            logic [SRC_W-CW-1:0] b_q;

            // Operand bits for the segments still to be added travel forward unchanged.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= src_a[SRC_W-1:CW];
                    b_q <= src_b[SRC_W-1:CW];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].ctl_q.valid;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign cout      = g_stage[STAGES-1].ctl_q.carry;

`ifdef PIPE_ADDER_OVF_EN
    assign ovf = (g_stage[STAGES-1].amsb_q == g_stage[STAGES-1].bmsb_q) &&
                 (sum[WIDTH-1] != g_stage[STAGES-1].amsb_q);
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (16/4 main instance, 8/1 variant).
// Overflow checks are included when PIPE_ADDER_OVF_EN is defined.
module tb_pipelined_adder;

    localparam int W  = 16;
    localparam int S  = 4;
    localparam int VW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [W-1:0]  a, b, sum;
    logic          v_in_valid, v_in_ready, v_cin, v_out_valid, v_cout;
    logic [VW-1:0] v_a, v_b, v_sum;
`ifdef PIPE_ADDER_OVF_EN
    logic          ovf, v_ovf;
`endif

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_exp;
    int   errors    = 0;
    int   checks    = 0;
    bit   rand_mode = 1'b0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PIPE_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    pipelined_adder #(.WIDTH(VW), .STAGES(1)) u_dut_w8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v_in_valid),
        .in_ready  (v_in_ready),
        .a         (v_a),
        .b         (v_b),
        .cin       (v_cin),
        .out_valid (v_out_valid),
        .out_ready (1'b1),
        .sum       (v_sum),
        .cout      (v_cout)
`ifdef PIPE_ADDER_OVF_EN
        ,
        .ovf       (v_ovf)
`endif
    );

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        exp_t       e;
        logic [W:0] full;
        full   = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (av[W-1] == bv[W-1]) && (full[W-1] != av[W-1]);
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Present one beat and hold it until the DUT takes it (bounded wait).
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        a = av;
        b = bv;
        cin = cv;
        in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
            if (rand_mode) out_ready = ($urandom_range(0, 1) != 0);
        end
        checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (S + 3) @(posedge clk);
        #1;
    endtask

    task automatic waitOutput(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    // Scoreboard monitor: pop/compare each emitted result, push each accepted beat.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                mon_exp = sb.pop_front();
                checkOutput("sb_sum", 32'(sum), 32'(mon_exp.sum));
                checkOutput("sb_cout", 32'(cout), 32'(mon_exp.cout));
`ifdef PIPE_ADDER_OVF_EN
                checkOutput("sb_ovf", 32'(ovf), 32'(mon_exp.ovf));
`endif
            end
        end
        if (rst_n && in_valid && in_ready) sb.push_back(model(a, b, cin));
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int            cycles;
        int            stale;
        logic [W-1:0]  stream_exp [3];
        logic          stream_cout [3];
        logic [3:0]    bubble_pat;
        exp_t          held;
        logic [VW:0]   vfull;

        stream_exp  = '{16'h2345, 16'h0101, 16'h0000};
        stream_cout = '{1'b0, 1'b0, 1'b1};
        bubble_pat  = 4'b0101;

        rst_n = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
        v_in_valid = 1'b0; v_a = '0; v_b = '0; v_cin = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        $display("[TB] reset state");
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_sum", 32'(sum), 32'd0);
        checkOutput("reset_cout", 32'(cout), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] carry across all segments");
        applyStimulus(16'hFFFF, 16'h0001, 1'b0);
        in_valid = 1'b0;
        waitOutput(cycles);
        checkOutput("carry_latency", 32'(cycles), 32'(S - 1));
        checkOutput("carry_sum", 32'(sum), 32'h0000);
        checkOutput("carry_cout", 32'(cout), 32'd1);
        drain();

        $display("[TB] streaming");
        applyStimulus(16'h1234, 16'h1111, 1'b0);
        applyStimulus(16'h00FF, 16'h0001, 1'b1);
        applyStimulus(16'h8000, 16'h8000, 1'b0);
        in_valid = 1'b0;
        waitOutput(cycles);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stream_valid", 32'(out_valid), 32'd1);
            checkOutput("stream_sum", 32'(sum), 32'(stream_exp[i]));
            checkOutput("stream_cout", 32'(cout), 32'(stream_cout[i]));
            @(posedge clk);
            #1;
        end
        checkOutput("stream_end_valid", 32'(out_valid), 32'd0);
        applyStimulus(16'hFFFF, 16'h0000, 1'b1);
        drain();

        $display("[TB] back-pressure");
        out_ready = 1'b0;
        applyStimulus(16'h0F0F, 16'h0101, 1'b0);
        applyStimulus(16'hFFF0, 16'h0020, 1'b1);
        applyStimulus(16'h7FFF, 16'h7FFF, 1'b0);
        applyStimulus(16'hABCD, 16'h1234, 1'b1);
        checkOutput("bp_full_valid", 32'(out_valid), 32'd1);
        a = 16'h5555; b = 16'hAAAA; cin = 1'b1; in_valid = 1'b1;
        held = model(16'h0F0F, 16'h0101, 1'b0);
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_hold_sum", 32'(sum), 32'(held.sum));
            checkOutput("bp_hold_cout", 32'(cout), 32'(held.cout));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();
        checkOutput("bp_all_drained", 32'(sb.size()), 32'd0);

        $display("[TB] bubbles");
        for (int i = 0; i < 4; i++) begin
            in_valid = (i % 2 == 0);
            a = 16'(16'h1000 * (i + 1));
            b = 16'h0234;
            cin = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            checkOutput("bubble_out_valid", 32'(out_valid), 32'(bubble_pat[j]));
            @(posedge clk);
            #1;
        end
        drain();

        $display("[TB] overflow corner beats");
        applyStimulus(16'h7FFF, 16'h0001, 1'b0);
        applyStimulus(16'h8000, 16'h8000, 1'b0);
        applyStimulus(16'h0001, 16'h0001, 1'b0);
        drain();

        $display("[TB] random stream with random back-pressure");
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
        rand_mode = 1'b0;
        drain();
        checkOutput("random_drained", 32'(sb.size()), 32'd0);

        $display("[TB] reset mid-flight");
        applyStimulus(16'h0001, 16'h0002, 1'b0);
        applyStimulus(16'h0003, 16'h0004, 1'b0);
        applyStimulus(16'h0005, 16'h0006, 1'b0);
        applyStimulus(16'h0007, 16'h0008, 1'b0);
        in_valid = 1'b0;
        checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
        #1 rst_n = 1'b0;
        sb.delete();
        #1;
        checkOutput("async_reset_valid", 32'(out_valid), 32'd0);
        checkOutput("async_reset_sum", 32'(sum), 32'd0);
        checkOutput("async_reset_cout", 32'(cout), 32'd0);
`ifdef PIPE_ADDER_OVF_EN
        checkOutput("async_reset_ovf", 32'(ovf), 32'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checkOutput("no_stale_results", 32'(stale), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(16'h4321, 16'h1234, 1'b1);
        in_valid = 1'b0;
        waitOutput(cycles);
        checkOutput("post_reset_latency", 32'(cycles), 32'(S - 1));
        checkOutput("post_reset_sum", 32'(sum), 32'h5556);
        drain();

        $display("[TB] WIDTH=8 STAGES=1 variant");
        v_a = 8'hFF; v_b = 8'h01; v_cin = 1'b0; v_in_valid = 1'b1;
        @(negedge clk);
        checkOutput("w8_in_ready", 32'(v_in_ready), 32'd1);
        checkOutput("w8_idle_valid", 32'(v_out_valid), 32'd0);
        @(posedge clk);
        #1;
        v_a = 8'h3C; v_b = 8'h5A; v_cin = 1'b1;
        checkOutput("w8_valid", 32'(v_out_valid), 32'd1);
        checkOutput("w8_sum", 32'(v_sum), 32'h00);
        checkOutput("w8_cout", 32'(v_cout), 32'd1);
`ifdef PIPE_ADDER_OVF_EN
        checkOutput("w8_ovf", 32'(v_ovf), 32'd0);
`endif
        @(posedge clk);
        #1;
        v_in_valid = 1'b0;
        vfull = {1'b0, 8'h3C} + {1'b0, 8'h5A} + 9'd1;
        checkOutput("w8_second_sum", 32'(v_sum), 32'(vfull[VW-1:0]));
        checkOutput("w8_second_cout", 32'(v_cout), 32'(vfull[VW]));
        @(posedge clk);
        #1;
        checkOutput("w8_bubble_valid", 32'(v_out_valid), 32'd0);

        checkOutput("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
